// File: rtl/mock8080_pkg.sv
// Shared definitions for the Mock8080 program memory and loader.
//   state_t     : loader/boot sequencer states
//   OPC_NOP     : opcode returned to the CPU while it is not running
//   DEF_ADDR_W  : default address width
//   DEF_DATA_W  : default data width
package mock8080_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic [7:0] OPC_NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BOOT = 2'd2,
    RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W.
// Registered read with read-before-write: a write and a read of the same
// address in one cycle returns the old contents.
// No reset: contents survive a block reset.
//   clk_qzt : clock
//   addr    : read/write address
//   we      : write enable
//   wdata   : write data
//   q       : registered read data
module ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_qzt,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_qzt) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Program/data memory for the Mock8080 CPU with a byte-stream loader.
// A load session writes ld_len bytes from ld_base, then the CPU is booted at
// ld_base by holding cpu_reset high for RST_HOLD cycles before running.
//
//   state | meaning
//   IDLE  | after reset; CPU disabled, loader not accepting
//   LOAD  | accepting loader bytes into memory, CPU disabled
//   BOOT  | CPU enabled with cpu_reset held high for RST_HOLD cycles
//   RUN   | CPU owns the memory port; ld_start begins a new load
//
// Ports:
//   clk_qzt, reset          : clock, async active-high reset
//   ld_start/ld_base/ld_len : start a session (ld_len 0 means full depth)
//   ld_valid/ld_data/ld_ready : loader byte handshake
//   cpu_addr/cpu_wdata/cpu_we/cpu_rdata : CPU memory bus
//   cpu_en/cpu_reset/cpu_res_addr       : CPU control
//   busy      : high in LOAD or BOOT
//   ld_count  : bytes accepted in the current or last session
module prog_mem_loader
  import mock8080_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RST_HOLD = 64
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] cpu_res_addr,
  output logic              busy,
  output logic [ADDR_W:0]   ld_count
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int BT_W  = $clog2(RST_HOLD + 1);

  state_t state, state_next;

  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  len;
  logic [BT_W-1:0]   boot_cnt;

  logic              start_ok;
  logic              accept;
  logic              last_byte;
  logic [CNT_W-1:0]  len_in;
  logic [CNT_W-1:0]  count_inc;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  // A length of zero selects the whole memory, hence the extra count bit.
  assign len_in    = (ld_len == '0) ? CNT_W'(2**ADDR_W) : {1'b0, ld_len};
  assign start_ok  = ld_start && ((state == IDLE) || (state == RUN));
  assign accept    = (state == LOAD) && ld_valid;
  assign count_inc = ld_count + CNT_W'(1);
  assign last_byte = accept && (count_inc == len);

  always_ff @(posedge clk_qzt or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    cpu_en     = 1'b0;
    cpu_reset  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) state_next = BOOT;
      end
      BOOT: begin
        cpu_en    = 1'b1;
        cpu_reset = 1'b1;
        busy      = 1'b1;
        if (boot_cnt == '0) state_next = RUN;
      end
      RUN: begin
        cpu_en = 1'b1;
        if (start_ok) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_qzt or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      len          <= '0;
      ld_count     <= '0;
      cpu_res_addr <= '0;
      boot_cnt     <= '0;
    end else begin
      if (start_ok) begin
        ptr          <= ld_base;
        cpu_res_addr <= ld_base;
        len          <= len_in;
        ld_count     <= '0;
      end else if (accept) begin
        ptr      <= ptr + ADDR_W'(1);
        ld_count <= count_inc;
      end

      // Down-counter loaded on LOAD->BOOT; terminal count at zero gives
      // exactly RST_HOLD cycles in BOOT.
      if (last_byte)              boot_cnt <= BT_W'(RST_HOLD - 1);
      else if (state == BOOT && boot_cnt != '0) boot_cnt <= boot_cnt - BT_W'(1);
    end
  end

  // Single write port: loader owns it in LOAD, CPU in RUN.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_we && (state == RUN);
    ram_wdata = cpu_wdata;
    if (state == LOAD) begin
      ram_addr  = ptr;
      ram_we    = accept;
      ram_wdata = ld_data;
    end
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_qzt (clk_qzt),
    .addr    (ram_addr),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .q       (ram_q)
  );

  assign cpu_rdata = (state == RUN) ? ram_q : DATA_W'(OPC_NOP);

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  logic       clk_qzt = 1'b0;
  logic       reset;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [7:0] ld_len;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;
  logic       cpu_en;
  logic       cpu_reset;
  logic [7:0] cpu_res_addr;
  logic       busy;
  logic [8:0] ld_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk_qzt = ~clk_qzt;

  prog_mem_loader #(.ADDR_W(8), .DATA_W(8), .RST_HOLD(64)) dut (
    .clk_qzt      (clk_qzt),
    .reset        (reset),
    .ld_start     (ld_start),
    .ld_base      (ld_base),
    .ld_len       (ld_len),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rdata    (cpu_rdata),
    .cpu_en       (cpu_en),
    .cpu_reset    (cpu_reset),
    .cpu_res_addr (cpu_res_addr),
    .busy         (busy),
    .ld_count     (ld_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_qzt);
  endtask

  task automatic start_load(input logic [7:0] base, input logic [7:0] len);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    cyc(1);
    ld_start = 1'b0;
  endtask

  // Counts BOOT cycles (cpu_reset high) with a bound; returns count.
  task automatic wait_run(input string tag, output int n);
    n = 0;
    while (cpu_reset && n < 300) begin
      n++;
      cyc(1);
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    cpu_addr = addr;
    cyc(1);
    check(tag, {24'd0, cpu_rdata}, {24'd0, exp});
  endtask

  int n;

  initial begin
    reset     = 1'b1;
    ld_start  = 1'b0;
    ld_base   = 8'h00;
    ld_len    = 8'h00;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    cpu_we    = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(10);
    check("idle_en",    {31'd0, cpu_en},    32'd0);
    check("idle_rst",   {31'd0, cpu_reset}, 32'd0);
    check("idle_ready", {31'd0, ld_ready},  32'd0);
    check("idle_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("idle_busy",  {31'd0, busy},      32'd0);
    check("idle_count", {23'd0, ld_count},  32'd0);

    // Load 1: base 0x10, three bytes back-to-back.
    start_load(8'h10, 8'd3);
    check("l1_ready", {31'd0, ld_ready}, 32'd1);
    check("l1_en",    {31'd0, cpu_en},   32'd0);
    ld_valid = 1'b1; ld_data = 8'hC3; cyc(1);
    ld_data = 8'h20; cyc(1);
    ld_data = 8'h00; cyc(1);
    ld_valid = 1'b0;
    check("l1_count",   {23'd0, ld_count},     32'd3);
    check("l1_ready_dn",{31'd0, ld_ready},     32'd0);
    check("l1_boot_rst",{31'd0, cpu_reset},    32'd1);
    check("l1_boot_en", {31'd0, cpu_en},       32'd1);
    check("l1_resaddr", {24'd0, cpu_res_addr}, 32'h10);
    check("l1_boot_nop",{24'd0, cpu_rdata},    32'h00);
    wait_run("l1_run", n);
    check("l1_hold", n, 64);
    check("l1_run_en",  {31'd0, cpu_en},    32'd1);
    check("l1_run_rst", {31'd0, cpu_reset}, 32'd0);
    rd("rd_10", 8'h10, 8'hC3);
    rd("rd_11", 8'h11, 8'h20);
    rd("rd_12", 8'h12, 8'h00);

    // Load 2: wrap across 0xFF with ld_valid toggling.
    start_load(8'hFE, 8'd4);
    check("l2_en_off", {31'd0, cpu_en}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      ld_valid = c[0];
      ld_data  = 8'hD0 + 8'(c / 2);
      cyc(1);
      if (c == 3) check("l2_mid_count", {23'd0, ld_count}, 32'd2);
    end
    check("l2_count", {23'd0, ld_count}, 32'd4);
    check("l2_boot",  {31'd0, cpu_reset}, 32'd1);
    ld_valid = 1'b1; ld_data = 8'hEE; cyc(1);
    ld_valid = 1'b0;
    check("l2_ignored", {23'd0, ld_count}, 32'd4);
    wait_run("l2_run", n);
    rd("rd_fe", 8'hFE, 8'hD0);
    rd("rd_ff", 8'hFF, 8'hD1);
    rd("rd_00", 8'h00, 8'hD2);
    rd("rd_01", 8'h01, 8'hD3);

    // Load 3: len 0 -> all 256 bytes, stray ld_start mid-load.
    start_load(8'h00, 8'h00);
    ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_data  = 8'(i) ^ 8'h5A;
      ld_start = (i == 100);
      ld_base  = (i == 100) ? 8'h77 : 8'h00;
      ld_len   = (i == 100) ? 8'd5  : 8'h00;
      cyc(1);
      if (i == 101) check("l3_mid_count", {23'd0, ld_count}, 32'd102);
    end
    ld_valid = 1'b0;
    ld_start = 1'b0;
    check("l3_count",   {23'd0, ld_count},     32'd256);
    check("l3_boot",    {31'd0, cpu_reset},    32'd1);
    check("l3_resaddr", {24'd0, cpu_res_addr}, 32'h00);
    wait_run("l3_run", n);
    rd("rd_ff_full", 8'hFF, 8'hA5);

    // CPU read-before-write.
    cpu_addr = 8'h40; cpu_wdata = 8'h55; cpu_we = 1'b1;
    cyc(1);
    cpu_we = 1'b0;
    check("rbw_old", {24'd0, cpu_rdata}, 32'h1A);
    cyc(1);
    check("rbw_new", {24'd0, cpu_rdata}, 32'h55);

    // Load 4: reset after 2 of 5 bytes.
    start_load(8'h80, 8'd5);
    ld_valid = 1'b1; ld_data = 8'hE1; cyc(1);
    ld_data = 8'hE2; cyc(1);
    ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_count", {23'd0, ld_count}, 32'd0);
    cyc(1);
    reset = 1'b0;
    // CPU write attempt in IDLE must not land.
    cpu_addr = 8'h40; cpu_wdata = 8'hAA; cpu_we = 1'b1;
    cyc(3);
    cpu_we = 1'b0;
    check("rst_en_off", {31'd0, cpu_en}, 32'd0);
    start_load(8'h90, 8'd1);
    check("l5_en_off", {31'd0, cpu_en}, 32'd0);
    ld_valid = 1'b1; ld_data = 8'h3C; cyc(1);
    ld_valid = 1'b0;
    wait_run("l5_run", n);
    rd("rd_80", 8'h80, 8'hE1);
    rd("rd_81", 8'h81, 8'hE2);
    rd("rd_82", 8'h82, 8'hD8);
    rd("rd_40_idle_we", 8'h40, 8'h55);
    rd("rd_90", 8'h90, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
Program/data memory for the Mock8080 CPU, with a byte-stream loader in front of it.
- Holds a 256x8 RAM and serves the CPU's address/data/write-enable bus.
- Between loads it keeps the CPU disabled, then boots it at the load base address through the CPU's reset/res_addr inputs.
- Sits directly downstream of the CPU's memory bus and upstream of the CPU's en/reset/res_addr control.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W.
DATA_W, 8, data width.
RST_HOLD, 64, clk_qzt cycles that cpu_reset stays high in BOOT; must span at least one CPU slave-clock rising edge.

Ports:
clk_qzt  in  1  system clock, the only clock.
reset  in  1  asynchronous, active-high reset.
ld_start  in  1  one-cycle pulse that begins a load session.
ld_base  in  ADDR_W  first address to write; sampled with ld_start.
ld_len  in  ADDR_W  byte count; 0 means 256; sampled with ld_start.
ld_valid  in  1  loader byte valid.
ld_data  in  DATA_W  loader byte.
ld_ready  out  1  block accepts a loader byte this cycle.
cpu_addr  in  ADDR_W  CPU memory address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_we  in  1  CPU write enable.
cpu_rdata  out  DATA_W  read data to the CPU.
cpu_en  out  1  CPU enable.
cpu_reset  out  1  CPU program-counter reset request.
cpu_res_addr  out  ADDR_W  CPU reset address.
busy  out  1  high in LOAD or BOOT.
ld_count  out  ADDR_W+1  bytes accepted in the current or last session.

Behaviour:
Reset values and memory:
- On reset: state=IDLE; every output is 0 (ld_ready, cpu_rdata, cpu_en, cpu_reset, cpu_res_addr, busy, ld_count).
- Memory contents are not touched by reset.

States:
- IDLE: CPU disabled, ld_ready=0.
  - ld_start -> LOAD: latch ld_base into ptr and cpu_res_addr, latch ld_len (0 -> 256) into len, clear ld_count.
- LOAD: ld_ready=1, cpu_en=0, busy=1.
  - Each cycle with ld_valid&ld_ready: mem[ptr]<=ld_data; ptr<=ptr+1 (wraps 0xFF->0x00); ld_count++.
  - On the cycle the accepted byte makes ld_count==len: ld_ready drops the next cycle -> BOOT.
  - ld_valid while ld_ready=0 is ignored; the byte is not consumed.
- BOOT: cpu_en=1, cpu_reset=1, busy=1 for exactly RST_HOLD cycles (internal counter) -> RUN.
- RUN: cpu_en=1, cpu_reset=0, busy=0.
  - ld_start -> LOAD; cpu_en is low from the next cycle.

CPU port:
- Active only in RUN.
- cpu_rdata is registered: cpu_rdata <= mem[cpu_addr] every RUN cycle, giving 1-cycle latency.
- Read-before-write: a same-address write returns the old data that cycle and the new data the following cycle.
- cpu_we writes mem[cpu_addr]<=cpu_wdata in RUN only; ignored in all other states.
- Outside RUN, cpu_rdata is forced to 8'h00 (NOP).

Boundary conditions:
- ld_start during LOAD or BOOT is ignored.
- Loads wrap across address 0xFF; ld_len=0 writes all 256 locations.
- Reset mid-LOAD or mid-BOOT: return to IDLE; bytes already written remain in memory; the CPU stays disabled.
- ld_count saturates at len; it is 9 bits wide so the value 256 is representable.
- A single memory write port is shared by the loader (LOAD) and the CPU (RUN). No contention is possible because the two owners are state-exclusive.

Decomposition:
- Shared package mock8080_pkg: state enum {IDLE, LOAD, BOOT, RUN}; OPC_NOP=8'h00; ADDR_W/DATA_W defaults.
- One sub-module, ram_sp: 256x8 single-port synchronous RAM with registered read and read-before-write. The top-level holds the FSM, counters, and write-port mux.

Test Plan:
- Reset, then hold idle 10 cycles -> cpu_en=0, cpu_reset=0, ld_ready=0, cpu_rdata=00.
- ld_start with base=0x10, len=3; stream C3,20,00 with ld_valid held -> 3 bytes accepted in 3 cycles; ld_count=3; BOOT with cpu_reset=1 for 64 cycles and cpu_res_addr=0x10; then RUN; CPU reads of 0x10/0x11/0x12 return C3/20/00 one cycle later.
- ld_start with base=0xFE, len=4; stream with ld_valid toggling every other cycle -> writes land at FE,FF,00,01; only valid beats are counted.
- In RUN: cpu_we to 0x40 with data 0x55, same-cycle read of 0x40 -> old value; next cycle returns 0x55. cpu_we in IDLE -> no write.
- len=0 -> exactly 256 bytes accepted, ld_count=256, then BOOT. An ld_start pulsed mid-load is ignored.
- Reset asserted after 2 of 5 bytes -> IDLE immediately (async); the 2 bytes persist; cpu_en stays 0 until the next load completes.
